usb_speed_detect_chirp: RTL and testbench
=========================================

// Module: usb_speed_detect_chirp
// PURPOSE
//  Parametrised successor to the front-end USB speed autodetector. It watches PHY linestate in the fe_clk domain and reports LS/FS/HS.
//  Adds: a glitch filter on linestate, true HS chirp K-J pair counting, a chirp-gap timeout, and an error counter with a retry limit.
//  Runs entirely in fe_clk. Register-side restart must arrive already in fe_clk as a 1-cycle pulse; no internal CDC.
// PARAMETERS
//  pCOUNTER_WIDTH  24  width of timer and I_wait1/2/3
//  pFILTER_LEN     4   cycles linestate must be stable before accepted (>=1)
//  pCHIRP_PAIRS    3   host K->J transitions required to declare HS (1..15)
//  pMAX_RETRIES    8   consecutive errors before FAIL (1..255)
// PORTS
//  fe_clk         in   1   PHY clock; only clock
//  reset_n        in   1   asynchronous active-low reset
//  fe_linestate0  in   1   PHY linestate bit 0
//  fe_linestate1  in   1   PHY linestate bit 1
//  I_restart      in   1   1-cycle pulse: restart detection, clear error count
//  I_wait1        in   pCOUNTER_WIDTH  attach dwell (LS / FS-HS idle J)
//  I_wait2        in   pCOUNTER_WIDTH  max bus-reset SE0 before device chirp
//  I_wait3        in   pCOUNTER_WIDTH  max gap between linestate changes in chirp
//  O_speed        out  2   `USB_SPEED_AUTO/LS/FS/HS
//  O_done         out  1   high while state==DONE
//  O_fail         out  1   high while state==FAIL
//  O_err_count    out  8   errors since restart, saturates at 255
//  O_state        out  4   FSM state (debug)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, O_speed=AUTO, O_done=0, O_fail=0, O_err_count=0, timer=0, chirp_cnt=0, ls_f=2'b00.
//  Filter: raw={fe_linestate1,fe_linestate0}. A change in raw resets the stability count. ls_f takes raw after pFILTER_LEN consecutive equal cycles.
//    Latency from a stable raw change to ls_f is pFILTER_LEN+1 cycles. Pulses shorter than pFILTER_LEN never reach ls_f.
//  timer: cleared on every state change. Otherwise +1 per cycle, saturating at all-ones.
//    In CHIRP it is also cleared on any ls_f change. Compares use >=.
//  FSM (all decisions on ls_f; I_restart forces IDLE from any state, highest priority):
//   IDLE(0):   10->LS; 01->FSHS; else stay.
//   LS(1):     ls_f!=10->ERROR; timer>=I_wait1->DONE, speed LS.
//   FSHS(2):   ls_f!=01->ERROR; timer>=I_wait1->WAIT_SE0.
//   WAIT_SE0(3): 01 stay (no timeout); 00->RESET; 10/11->ERROR.
//   RESET(4):  timer>=I_wait2->ERROR (first priority); 10 (device chirp K)->CHIRP; 01->DONE, speed FS; 11->ERROR.
//   CHIRP(5):  chirp_cnt cleared on entry, +1 on each ls_f 10->01 transition.
//              chirp_cnt==pCHIRP_PAIRS->DONE, speed HS.
//              timer>=I_wait3: ls_f==01 and chirp_cnt==0 -> DONE, speed FS (host ignored chirp); otherwise -> ERROR.
//              11->ERROR.
//   DONE(6):   hold until I_restart.
//   ERROR(7):  1 cycle. O_err_count+=1 (sat). Next state FAIL if the new count >= pMAX_RETRIES, else IDLE.
//   FAIL(8):   hold until I_restart.
//  O_speed is registered on the same edge the FSM enters DONE and holds through DONE. It is AUTO in every other state.
//  I_restart: next edge state=IDLE, timer=0, chirp_cnt=0, O_err_count=0, O_speed=AUTO.
//    A restart coinciding with an ERROR cycle does not increment the count.
//  Each I_waitN is used live each cycle. Lowering it below the current timer value exits on the next cycle; there is no wrap.
//  Encodings 9-15 are illegal and go to IDLE.
// TESTING
//  1. pFILTER_LEN=4, I_wait1=100, raw=10 held -> LS entered at cycle 5; DONE, O_speed=LS after 101 more cycles.
//  2. raw=01 for 200, I_wait1=100, then 00 for 50, then 01, I_wait2=1000 -> DONE, O_speed=FS.
//  3. As 2, then 00, 10 for 300, then 3x (10 for 200, 01 for 200), I_wait3=500 -> DONE, O_speed=HS on the 3rd K->J.
//  4. raw=10 with 2-cycle 01 glitches every 20 cycles, I_wait1=100 -> glitches filtered, O_speed=LS, O_err_count=0.
//  5. pMAX_RETRIES=3, raw=10 for 10 cycles then 11, repeated (I_wait1=100) -> O_err_count=3, O_fail=1; I_restart -> IDLE, count 0.
//  6. reset_n low mid-CHIRP (async) -> all outputs at reset values before the next fe_clk edge. I_restart in DONE -> IDLE, O_speed=AUTO next cycle.

Source files
------------

// File: rtl/usb_speed_detect_chirp.sv
// USB speed autodetector running entirely in fe_clk.
// Filters PHY linestate, walks the attach / bus-reset / chirp sequence and
// reports LS, FS or HS, with a chirp-gap timeout and an error retry limit.
module usb_speed_detect_chirp #(
  parameter int pCOUNTER_WIDTH = 24,
  parameter int pFILTER_LEN    = 4,
  parameter int pCHIRP_PAIRS   = 3,
  parameter int pMAX_RETRIES   = 8
) (
  input  logic                      fe_clk,
  input  logic                      reset_n,
  input  logic                      fe_linestate0,
  input  logic                      fe_linestate1,
  input  logic                      I_restart,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait3,
  output logic [1:0]                O_speed,
  output logic                      O_done,
  output logic                      O_fail,
  output logic [7:0]                O_err_count,
  output logic [3:0]                O_state
);

  localparam logic [1:0] SPEED_AUTO = 2'd0;
  localparam logic [1:0] SPEED_LS   = 2'd1;
  localparam logic [1:0] SPEED_FS   = 2'd2;
  localparam logic [1:0] SPEED_HS   = 2'd3;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam int              FCW      = $clog2(pFILTER_LEN + 1);
  localparam logic [FCW-1:0]  STAB_MAX = FCW'(pFILTER_LEN - 1);
  localparam logic [3:0]      PAIRS    = 4'(pCHIRP_PAIRS);
  localparam logic [7:0]      MAXR     = 8'(pMAX_RETRIES);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LS       = 4'd1,
    ST_FSHS     = 4'd2,
    ST_WAIT_SE0 = 4'd3,
    ST_RESET    = 4'd4,
    ST_CHIRP    = 4'd5,
    ST_DONE     = 4'd6,
    ST_ERROR    = 4'd7,
    ST_FAIL     = 4'd8
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [1:0]                w_raw;
  logic [1:0]                r_raw_q;
  logic [FCW-1:0]            r_stab;
  logic [1:0]                r_ls_f;
  logic [1:0]                r_ls_d;
  logic [pCOUNTER_WIDTH-1:0] r_timer;
  logic [3:0]                r_chirp_cnt;
  logic [7:0]                r_err;
  logic [7:0]                w_err_inc;
  logic [1:0]                r_speed;
  logic [1:0]                w_speed_nxt;
  logic                      w_kj;

  assign w_raw     = {fe_linestate1, fe_linestate0};
  assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  assign w_kj      = (r_ls_d == LS_K) && (r_ls_f == LS_J);

  // Glitch filter: accept raw only after it has been equal for pFILTER_LEN+1 samples.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raw_q <= 2'b00;
      r_stab  <= '0;
      r_ls_f  <= 2'b00;
      r_ls_d  <= 2'b00;
    end else begin
      r_raw_q <= w_raw;
      r_ls_d  <= r_ls_f;
      if (w_raw != r_raw_q)
        r_stab <= '0;
      else if (r_stab != STAB_MAX)
        r_stab <= r_stab + 1'b1;
      if ((w_raw == r_raw_q) && (r_stab == STAB_MAX))
        r_ls_f <= r_raw_q;
    end
  end

  // Next-state and speed decision on the filtered linestate.
  always_comb begin
    w_next      = r_state;
    w_speed_nxt = SPEED_AUTO;
    case (r_state)
      ST_IDLE: begin
        if (r_ls_f == LS_K)      w_next = ST_LS;
        else if (r_ls_f == LS_J) w_next = ST_FSHS;
      end
      ST_LS: begin
        if (r_ls_f != LS_K) w_next = ST_ERROR;
        else if (r_timer >= I_wait1) begin
          w_next      = ST_DONE;
          w_speed_nxt = SPEED_LS;
        end
      end
      ST_FSHS: begin
        if (r_ls_f != LS_J)          w_next = ST_ERROR;
        else if (r_timer >= I_wait1) w_next = ST_WAIT_SE0;
      end
      ST_WAIT_SE0: begin
        if (r_ls_f == LS_SE0)     w_next = ST_RESET;
        else if (r_ls_f != LS_J) w_next = ST_ERROR;
      end
      ST_RESET: begin
        if (r_timer >= I_wait2)    w_next = ST_ERROR;
        else if (r_ls_f == LS_K)   w_next = ST_CHIRP;
        else if (r_ls_f == LS_J) begin
          w_next      = ST_DONE;
          w_speed_nxt = SPEED_FS;
        end else if (r_ls_f == LS_SE1) w_next = ST_ERROR;
      end
      ST_CHIRP: begin
        if (r_chirp_cnt == PAIRS) begin
          w_next      = ST_DONE;
          w_speed_nxt = SPEED_HS;
        end else if (r_timer >= I_wait3) begin
          // A host that never answered the device chirp leaves the bus in J.
          if ((r_ls_f == LS_J) && (r_chirp_cnt == 4'd0)) begin
            w_next      = ST_DONE;
            w_speed_nxt = SPEED_FS;
          end else begin
            w_next = ST_ERROR;
          end
        end else if (r_ls_f == LS_SE1) w_next = ST_ERROR;
      end
      ST_DONE:  w_speed_nxt = r_speed;
      ST_ERROR: w_next = (w_err_inc >= MAXR) ? ST_FAIL : ST_IDLE;
      ST_FAIL:  w_next = ST_FAIL;
      default:  w_next = ST_IDLE;
    endcase
    if (I_restart) begin
      w_next      = ST_IDLE;
      w_speed_nxt = SPEED_AUTO;
    end
  end

  // State, reported speed and error count registers.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_speed <= SPEED_AUTO;
      r_err   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_speed <= w_speed_nxt;
      if (I_restart)
        r_err <= 8'd0;
      else if (r_state == ST_ERROR)
        r_err <= w_err_inc;
    end
  end

  // Dwell timer: restarts on state change and on linestate activity during chirp.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (I_restart || (w_next != r_state)) begin
      r_timer <= '0;
    end else if ((r_state == ST_CHIRP) && (r_ls_f != r_ls_d)) begin
      r_timer <= '0;
    end else if (r_timer != '1) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Host K->J pair counter, only live while in CHIRP.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chirp_cnt <= 4'd0;
    end else if (I_restart || (r_state != ST_CHIRP)) begin
      r_chirp_cnt <= 4'd0;
    end else if (w_kj && (r_chirp_cnt != 4'hF)) begin
      r_chirp_cnt <= r_chirp_cnt + 4'd1;
    end
  end

  assign O_speed     = r_speed;
  assign O_done      = (r_state == ST_DONE);
  assign O_fail      = (r_state == ST_FAIL);
  assign O_err_count = r_err;
  assign O_state     = r_state;

endmodule

// File: tb/tb_usb_speed_detect_chirp.sv
// Directed bench for usb_speed_detect_chirp with a behavioural reference model.
module tb_usb_speed_detect_chirp;

  localparam int CW    = 24;
  localparam int FL    = 4;
  localparam int PAIRS = 3;
  localparam int MAXR  = 3;
  localparam int TMAX  = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic [1:0]    raw;
  logic          restart;
  logic [CW-1:0] w1, w2, w3;
  logic [1:0]    O_speed;
  logic          O_done, O_fail;
  logic [7:0]    O_err_count;
  logic [3:0]    O_state;

  int n_chk  = 0;
  int n_fail = 0;

  usb_speed_detect_chirp #(
    .pCOUNTER_WIDTH(CW), .pFILTER_LEN(FL), .pCHIRP_PAIRS(PAIRS), .pMAX_RETRIES(MAXR)
  ) dut (
    .fe_clk(clk), .reset_n(reset_n),
    .fe_linestate0(raw[0]), .fe_linestate1(raw[1]),
    .I_restart(restart), .I_wait1(w1), .I_wait2(w2), .I_wait3(w3),
    .O_speed(O_speed), .O_done(O_done), .O_fail(O_fail),
    .O_err_count(O_err_count), .O_state(O_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Spec state numbers: 0 IDLE,1 LS,2 FSHS,3 WAIT_SE0,4 RESET,5 CHIRP,6 DONE,7 ERROR,8 FAIL
  // Linestate values: 0 SE0, 1 J, 2 K, 3 SE1
  int m_state, m_timer, m_cnt, m_err, m_speed, m_ls, m_ls_last;
  int m_hist[$];

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_cnt = 0; m_err = 0; m_speed = 0;
    m_ls = 0; m_ls_last = 0;
    m_hist = {};
    m_hist.push_back(0);
  endtask

  task automatic model_step();
    int  rv, new_ls, ns, spd, errn;
    bit  stable, kj;
    rv = int'(raw);
    m_hist.push_back(rv);
    if (m_hist.size() > FL + 1) m_hist.delete(0);
    stable = (m_hist.size() == FL + 1);
    foreach (m_hist[i]) if (m_hist[i] != rv) stable = 0;
    new_ls = stable ? rv : m_ls;
    kj   = (m_ls_last == 2) && (m_ls == 1);
    errn = (m_err < 255) ? m_err + 1 : 255;
    ns = m_state; spd = 0;
    case (m_state)
      0: ns = (m_ls == 2) ? 1 : (m_ls == 1) ? 2 : 0;
      1: if (m_ls != 2) ns = 7; else if (m_timer >= int'(w1)) begin ns = 6; spd = 1; end
      2: if (m_ls != 1) ns = 7; else if (m_timer >= int'(w1)) ns = 3;
      3: if (m_ls == 0) ns = 4; else if (m_ls != 1) ns = 7;
      4: if (m_timer >= int'(w2)) ns = 7;
         else if (m_ls == 2) ns = 5;
         else if (m_ls == 1) begin ns = 6; spd = 2; end
         else if (m_ls == 3) ns = 7;
      5: if (m_cnt == PAIRS) begin ns = 6; spd = 3; end
         else if (m_timer >= int'(w3)) begin
           if (m_ls == 1 && m_cnt == 0) begin ns = 6; spd = 2; end else ns = 7;
         end else if (m_ls == 3) ns = 7;
      6: begin ns = 6; spd = m_speed; end
      7: ns = (errn >= MAXR) ? 8 : 0;
      8: ns = 8;
      default: ns = 0;
    endcase
    if (restart) begin ns = 0; spd = 0; end
    if (restart) m_err = 0; else if (m_state == 7) m_err = errn;
    if (restart || ns != m_state) m_timer = 0;
    else if (m_state == 5 && m_ls != m_ls_last) m_timer = 0;
    else if (m_timer < TMAX) m_timer = m_timer + 1;
    if (ns != 5 || m_state != 5) m_cnt = 0;
    else if (kj) m_cnt = m_cnt + 1;
    m_speed   = (ns == 6) ? spd : 0;
    m_ls_last = m_ls;
    m_ls      = new_ls;
    m_state   = ns;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("state", 32'(O_state), m_state);
    chk("speed", 32'(O_speed), m_speed);
    chk("done",  32'(O_done),  32'(m_state == 6));
    chk("fail",  32'(O_fail),  32'(m_state == 8));
    chk("errcnt", 32'(O_err_count), m_err);
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [1:0] v, input int n);
    raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_restart();
    hold(2'b00, 8);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; raw = 2'b00; restart = 1'b0;
    w1 = 24'd100; w2 = 24'd1000; w3 = 24'd500;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(O_state), 0);
    chk("rst_speed", 32'(O_speed), 0);
    chk("rst_done",  32'(O_done), 0);
    chk("rst_fail",  32'(O_fail), 0);
    chk("rst_err",   32'(O_err_count), 0);
    reset_n = 1'b1;
    hold(2'b00, 5);

    // LS attach: LS entered on the 6th edge, DONE 101 edges later.
    hold(2'b10, 5);
    chk("ls_not_yet", 32'(O_state), 0);
    hold(2'b10, 1);
    chk("ls_entered", 32'(O_state), 1);
    chk("model_ls_entered", m_state, 1);
    hold(2'b10, 100);
    chk("ls_dwell", 32'(O_state), 1);
    hold(2'b10, 1);
    chk("ls_done_state", 32'(O_state), 6);
    chk("ls_done_speed", 32'(O_speed), 1);
    chk("model_ls_speed", m_speed, 1);

    // LS attach with short J glitches.
    do_restart();
    for (int i = 0; i < 8; i++) begin
      hold(2'b10, 18);
      hold(2'b01, 2);
    end
    hold(2'b10, 20);
    chk("glitch_speed", 32'(O_speed), 1);
    chk("glitch_done",  32'(O_done), 1);
    chk("glitch_err",   32'(O_err_count), 0);

    // FS: idle J, bus reset, back to J without chirp.
    do_restart();
    hold(2'b01, 200);
    chk("fs_wait_se0", 32'(O_state), 3);
    hold(2'b00, 50);
    chk("fs_in_reset", 32'(O_state), 4);
    hold(2'b01, 30);
    chk("fs_speed", 32'(O_speed), 2);
    chk("fs_done",  32'(O_done), 1);

    // HS: device chirp K, then three host K-J pairs.
    do_restart();
    hold(2'b01, 200);
    hold(2'b00, 50);
    hold(2'b10, 300);
    chk("hs_in_chirp", 32'(O_state), 5);
    hold(2'b00, 20);
    for (int i = 0; i < PAIRS - 1; i++) begin
      hold(2'b10, 200);
      hold(2'b01, 200);
    end
    hold(2'b10, 200);
    hold(2'b01, 6);
    chk("hs_before_done", 32'(O_state), 5);
    hold(2'b01, 1);
    chk("hs_done_state", 32'(O_state), 6);
    chk("hs_speed", 32'(O_speed), 3);
    hold(2'b01, 10);

    // Restart from DONE returns to IDLE with AUTO speed after one edge.
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_state", 32'(O_state), 0);
    chk("restart_speed", 32'(O_speed), 0);
    hold(2'b01, 5);

    // Host ignores the chirp: J held past I_wait3 with no K-J pair -> FS.
    w3 = 24'd100;
    do_restart();
    hold(2'b01, 200);
    hold(2'b00, 50);
    hold(2'b10, 50);
    hold(2'b00, 10);
    hold(2'b01, 150);
    chk("chirp_to_fs_speed", 32'(O_speed), 2);
    chk("chirp_to_fs_state", 32'(O_state), 6);
    w3 = 24'd500;

    // Bus reset SE0 longer than I_wait2 -> one error, back to IDLE.
    w2 = 24'd60;
    do_restart();
    hold(2'b01, 200);
    hold(2'b00, 100);
    chk("se0_timeout_err",   32'(O_err_count), 1);
    chk("se0_timeout_state", 32'(O_state), 0);
    w2 = 24'd1000;

    // Repeated LS attach errors reach the retry limit.
    do_restart();
    chk("retry_cleared", 32'(O_err_count), 0);
    for (int i = 0; i < MAXR; i++) begin
      hold(2'b10, 10);
      hold(2'b11, 10);
    end
    chk("retry_err",  32'(O_err_count), MAXR);
    chk("retry_fail", 32'(O_fail), 1);
    chk("retry_state", 32'(O_state), 8);
    do_restart();
    chk("retry_restart_state", 32'(O_state), 0);
    chk("retry_restart_err",   32'(O_err_count), 0);

    // Asynchronous reset in the middle of a chirp.
    hold(2'b01, 200);
    hold(2'b00, 50);
    hold(2'b10, 100);
    chk("async_pre_state", 32'(O_state), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_state", 32'(O_state), 0);
    chk("async_speed", 32'(O_speed), 0);
    chk("async_done",  32'(O_done), 0);
    chk("async_fail",  32'(O_fail), 0);
    chk("async_err",   32'(O_err_count), 0);
    @(negedge clk);
    raw = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hold(2'b00, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
